// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_fader
//  Description : Per-channel PWM fader for a 4-bit LED pattern. Each LED
//                ramps its duty up or down one step per fade tick. A bypass
//                mode switches the LEDs hard.
//  Revision    : 1.0  initial release
// ============================================================================
module led_pwm_fader #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 19531
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] led_in,
    input  logic       en,
    output logic [3:0] led_out,
    output logic       busy
);

    localparam int                    c_N_CH      = 4;
    localparam logic [PWM_BITS-1:0]   c_MAX       = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0]   c_PWM_LAST  = c_MAX - 1'b1;
    localparam int                    c_STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [c_STEP_W-1:0]   c_STEP_LAST = c_STEP_W'(STEP_CYCLES - 1);

    logic [3:0]          r_led_in_q;
    logic [c_STEP_W-1:0] r_step_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_step_tick;
    logic [c_N_CH-1:0]   w_pwm_on;
    logic [c_N_CH-1:0]   w_mismatch;

    assign w_step_tick = (r_step_cnt == c_STEP_LAST);

    // Input stage, fade-step prescaler and free-running PWM counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_in_q <= '0;
            r_step_cnt <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_led_in_q <= led_in;
            r_step_cnt <= w_step_tick ? '0 : r_step_cnt + 1'b1;
            r_pwm_cnt  <= (r_pwm_cnt == c_PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < c_N_CH; gi++) begin : g_ch
            logic [PWM_BITS-1:0] r_duty;
            logic [PWM_BITS-1:0] w_duty_next;
            logic [PWM_BITS-1:0] w_target;

            assign w_target = r_led_in_q[gi] ? c_MAX : '0;

            // Saturating one-step move toward the target; reversal happens
            // naturally from the current duty because only the sign changes.
            always_comb begin
                w_duty_next = r_duty;
                if (!en) begin
                    w_duty_next = w_target;
                end else if (w_step_tick) begin
                    if (r_led_in_q[gi] && (r_duty != c_MAX)) begin
                        w_duty_next = r_duty + 1'b1;
                    end else if (!r_led_in_q[gi] && (r_duty != '0)) begin
                        w_duty_next = r_duty - 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_duty <= '0;
                end else begin
                    r_duty <= w_duty_next;
                end
            end

            assign w_pwm_on[gi]   = (r_pwm_cnt < r_duty);
            assign w_mismatch[gi] = (w_duty_next != w_target);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= '0;
            busy    <= 1'b0;
        end else if (en) begin
            led_out <= w_pwm_on;
            busy    <= |w_mismatch;
        end else begin
            led_out <= r_led_in_q;
            busy    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pwm_fader
//  Description : Directed self-checking bench for led_pwm_fader
//                (PWM_BITS=3 -> MAX=7, STEP_CYCLES=4, 20 ns clock).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_pwm_fader;

    localparam int PWM_BITS    = 3;
    localparam int STEP_CYCLES = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] led_in = 4'b0000;
    logic       en     = 1'b1;
    logic [3:0] led_out;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    led_pwm_fader #(
        .PWM_BITS    (PWM_BITS),
        .STEP_CYCLES (STEP_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led_in  (led_in),
        .en      (en),
        .led_out (led_out),
        .busy    (busy)
    );

    always #10 clk = ~clk;

    // Advance one rising edge; outputs are then sampled at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Hold reset for two cycles, release on a falling edge (edge count 0).
    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        led_in = 4'b0000;
        en     = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        tests_run++;
        if (led_out !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: led_out=%b busy=%b expected 0000/0", led_out, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            step();
            tests_run++;
            if (led_out !== 4'b0000 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle k=%0d: led_out=%b busy=%b expected 0000/0", k, led_out, busy);
            end
        end
    endtask

    task automatic test_ramp_up();
        led_in = 4'b0001;
        en     = 1'b1;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            int j, d;
            logic [3:0] exp_led;
            logic       exp_busy;
            step();
            j = k - 1;
            d = (j / 4 > 7) ? 7 : j / 4;
            exp_led  = {3'b000, logic'((j % 7) < d)};
            exp_busy = (k >= 2) && (k <= 27);
            tests_run++;
            if (led_out !== exp_led) begin
                tests_failed++;
                $display("FAIL ramp_up_led k=%0d: led_out=%b expected %b", k, led_out, exp_led);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL ramp_up_busy k=%0d: busy=%b expected %b", k, busy, exp_busy);
            end
        end
    endtask

    task automatic test_reverse();
        led_in = 4'b0001;
        en     = 1'b1;
        apply_reset();
        repeat (12) step();
        led_in = 4'b0000;
        for (int k = 13; k <= 36; k++) begin
            int j, d;
            logic [3:0] exp_led;
            logic       exp_busy;
            step();
            j = k - 1;
            d = (j < 16) ? 3 : (j < 20) ? 2 : (j < 24) ? 1 : 0;
            exp_led  = {3'b000, logic'((j % 7) < d)};
            exp_busy = (k <= 23);
            tests_run++;
            if (led_out !== exp_led) begin
                tests_failed++;
                $display("FAIL reverse_led k=%0d: led_out=%b expected %b", k, led_out, exp_led);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL reverse_busy k=%0d: busy=%b expected %b", k, busy, exp_busy);
            end
        end
    endtask

    task automatic test_bypass();
        led_in = 4'b1010;
        en     = 1'b0;
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] exp_led;
            step();
            exp_led = (k >= 2) ? 4'b1010 : 4'b0000;
            tests_run++;
            if (led_out !== exp_led || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL bypass k=%0d: led_out=%b busy=%b expected %b/0", k, led_out, busy, exp_led);
            end
        end
        en     = 1'b1;
        led_in = 4'b0000;
        for (int k = 11; k <= 45; k++) begin
            int j, d;
            logic       b;
            logic [3:0] exp_led;
            logic       exp_busy;
            step();
            j = k - 1;
            d = (j < 12) ? 7 : 6 - (j - 12) / 4;
            if (d < 0) d = 0;
            b = logic'((j % 7) < d);
            exp_led  = {b, 1'b0, b, 1'b0};
            exp_busy = (k >= 12) && (k <= 35);
            tests_run++;
            if (led_out !== exp_led) begin
                tests_failed++;
                $display("FAIL bypass_fade_led k=%0d: led_out=%b expected %b", k, led_out, exp_led);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL bypass_fade_busy k=%0d: busy=%b expected %b", k, busy, exp_busy);
            end
        end
    endtask

    task automatic test_async_reset();
        led_in = 4'b0001;
        en     = 1'b1;
        apply_reset();
        repeat (22) step();
        tests_run++;
        if (led_out !== 4'b0001 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: led_out=%b busy=%b expected 0001/1", led_out, busy);
        end
        #3 rst = 1'b1;
        #2;
        tests_run++;
        if (led_out !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: led_out=%b busy=%b expected 0000/0", led_out, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            int j, d;
            logic [3:0] exp_led;
            step();
            j = k - 1;
            d = j / 4;
            exp_led = {3'b000, logic'((j % 7) < d)};
            tests_run++;
            if (led_out !== exp_led) begin
                tests_failed++;
                $display("FAIL restart_led k=%0d: led_out=%b expected %b", k, led_out, exp_led);
            end
        end
    endtask

    task automatic test_mixed();
        led_in = 4'b1111;
        en     = 1'b1;
        apply_reset();
        repeat (16) step();
        led_in = 4'b0101;
        for (int k = 17; k <= 45; k++) begin
            int j, p, d_up, d_dn;
            logic       b_up, b_dn;
            logic [3:0] exp_led;
            logic       exp_busy;
            step();
            j    = k - 1;
            p    = j % 7;
            d_up = 4 + (j - 16) / 4;
            if (d_up > 7) d_up = 7;
            d_dn = 4 - (j - 16) / 4;
            if (d_dn < 0) d_dn = 0;
            b_up = logic'(p < d_up);
            b_dn = logic'(p < d_dn);
            exp_led  = {b_dn, b_up, b_dn, b_up};
            exp_busy = (k <= 31);
            tests_run++;
            if (led_out !== exp_led) begin
                tests_failed++;
                $display("FAIL mixed_led k=%0d: led_out=%b expected %b", k, led_out, exp_led);
            end
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL mixed_busy k=%0d: busy=%b expected %b", k, busy, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reverse();
        test_bypass();
        test_async_reset();
        test_mixed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
